// File: rtl/nand4_sweep_ctrl.sv
// nand4_sweep_ctrl
// Exhaustive functional-test sequencer for one 4-input NAND cell instance.
// It walks vectors 0..15 onto the cell inputs and waits SETTLE_CYCLES per
// vector. It then samples dut_y against EXPECT_MASK[vec] and accumulates an
// error count, the first failing vector and a pass flag.
//
// Ports:
//   clk              clock, rising edge
//   rst_n            asynchronous active-low reset
//   start            one-cycle sweep request (honoured only in IDLE)
//   abort            terminate a running sweep (wins over start in IDLE)
//   dut_a..dut_d     cell inputs = vec[3..0], 0 when not sweeping
//   dut_y            cell output under test
//   busy             high while in SETTLE or SAMPLE
//   done             one-cycle pulse on sweep completion
//   pass             last completed sweep had no mismatches
//   err_count        mismatches in current/last sweep (0..16)
//   first_fail_vec   vector index of the first mismatch
//   first_fail_valid first_fail_vec holds a captured value
module nand4_sweep_ctrl #(
   parameter int unsigned SETTLE_CYCLES = 2,
   parameter logic [15:0] EXPECT_MASK   = 16'h7FFF
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       abort,
   output logic       dut_a,
   output logic       dut_b,
   output logic       dut_c,
   output logic       dut_d,
   input  logic       dut_y,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [4:0] err_count,
   output logic [3:0] first_fail_vec,
   output logic       first_fail_valid
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SETTLE = 2'd1,
      S_SAMPLE = 2'd2,
      S_DONE   = 2'd3
   } state_t;

   localparam logic [3:0] LAST_CNT = 4'(SETTLE_CYCLES - 1);

   state_t     r_state, w_state_nxt;
   logic [3:0] r_vec, w_vec_nxt;
   logic [3:0] r_cnt, w_cnt_nxt;
   logic [4:0] r_err, w_err_nxt;
   logic [3:0] r_ffv, w_ffv_nxt;
   logic       r_ffvld, w_ffvld_nxt;
   logic       r_pass, w_pass_nxt;
   logic       r_busy, w_busy_nxt;
   logic       r_done, w_done_nxt;
   logic       w_mismatch;

   assign w_mismatch = (dut_y != EXPECT_MASK[r_vec]);

   always_comb begin
      w_state_nxt = r_state;
      w_vec_nxt   = r_vec;
      w_cnt_nxt   = r_cnt;
      w_err_nxt   = r_err;
      w_ffv_nxt   = r_ffv;
      w_ffvld_nxt = r_ffvld;
      w_pass_nxt  = r_pass;

      case (r_state)
         S_IDLE: begin
            if (start && !abort) begin
               w_vec_nxt   = 4'd0;
               w_cnt_nxt   = 4'd0;
               w_err_nxt   = 5'd0;
               w_ffv_nxt   = 4'd0;
               w_ffvld_nxt = 1'b0;
               w_pass_nxt  = 1'b0;
               w_state_nxt = S_SETTLE;
            end
         end
         S_SETTLE: begin
            if (abort) begin
               w_state_nxt = S_IDLE;
               w_vec_nxt   = 4'd0;
               w_cnt_nxt   = 4'd0;
               w_pass_nxt  = 1'b0;
            end else if (r_cnt == LAST_CNT) begin
               w_state_nxt = S_SAMPLE;
            end else begin
               w_cnt_nxt = r_cnt + 4'd1;
            end
         end
         S_SAMPLE: begin
            // An abort discards this cycle's comparison entirely.
            if (abort) begin
               w_state_nxt = S_IDLE;
               w_vec_nxt   = 4'd0;
               w_cnt_nxt   = 4'd0;
               w_pass_nxt  = 1'b0;
            end else begin
               if (w_mismatch) begin
                  if (r_err != 5'd16) w_err_nxt = r_err + 5'd1;
                  if (!r_ffvld) begin
                     w_ffv_nxt   = r_vec;
                     w_ffvld_nxt = 1'b1;
                  end
               end
               w_cnt_nxt = 4'd0;
               if (r_vec == 4'd15) begin
                  // vec returns to 0 so the cell inputs drop on DONE entry;
                  // pass uses the count including this final sample.
                  w_state_nxt = S_DONE;
                  w_vec_nxt   = 4'd0;
                  w_pass_nxt  = (w_err_nxt == 5'd0);
               end else begin
                  w_state_nxt = S_SETTLE;
                  w_vec_nxt   = r_vec + 4'd1;
               end
            end
         end
         S_DONE: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase

      // busy/done are registered from the next state so they line up
      // exactly with the state they describe.
      w_busy_nxt = (w_state_nxt == S_SETTLE) || (w_state_nxt == S_SAMPLE);
      w_done_nxt = (w_state_nxt == S_DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_vec   <= 4'd0;
         r_cnt   <= 4'd0;
         r_err   <= 5'd0;
         r_ffv   <= 4'd0;
         r_ffvld <= 1'b0;
         r_pass  <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_vec   <= w_vec_nxt;
         r_cnt   <= w_cnt_nxt;
         r_err   <= w_err_nxt;
         r_ffv   <= w_ffv_nxt;
         r_ffvld <= w_ffvld_nxt;
         r_pass  <= w_pass_nxt;
         r_busy  <= w_busy_nxt;
         r_done  <= w_done_nxt;
      end
   end

   assign dut_a            = r_vec[3];
   assign dut_b            = r_vec[2];
   assign dut_c            = r_vec[1];
   assign dut_d            = r_vec[0];
   assign busy             = r_busy;
   assign done             = r_done;
   assign pass             = r_pass;
   assign err_count        = r_err;
   assign first_fail_vec   = r_ffv;
   assign first_fail_valid = r_ffvld;

endmodule

// File: tb/tb_nand4_sweep_ctrl.sv
// tb_nand4_sweep_ctrl
// Directed bench for nand4_sweep_ctrl. A behavioural cell model selected by
// y_mode drives dut_y. A second instance runs with SETTLE_CYCLES=1.
module tb_nand4_sweep_ctrl;

   localparam int M_NAND  = 0;
   localparam int M_AOI   = 1;
   localparam int M_STK1  = 2;
   localparam int M_STK0  = 3;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       abort = 1'b0;
   logic       dut_a, dut_b, dut_c, dut_d;
   logic       dut_y;
   logic       busy, done, pass;
   logic [4:0] err_count;
   logic [3:0] first_fail_vec;
   logic       first_fail_valid;

   logic       start2 = 1'b0;
   logic       a2, b2, c2, d2, y2;
   logic       busy2, done2, pass2;
   logic [4:0] err2;
   logic [3:0] ffv2;
   logic       ffvld2;

   int y_mode = M_NAND;
   int n_chk  = 0;
   int n_bad  = 0;

   always #5 clk = ~clk;

   always_comb begin
      case (y_mode)
         M_AOI:   dut_y = ~((dut_a & dut_b) | (dut_c & dut_d));
         M_STK1:  dut_y = 1'b1;
         M_STK0:  dut_y = 1'b0;
         default: dut_y = ~(dut_a & dut_b & dut_c & dut_d);
      endcase
   end

   assign y2 = ~(a2 & b2 & c2 & d2);

   nand4_sweep_ctrl u_dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
      .dut_a(dut_a), .dut_b(dut_b), .dut_c(dut_c), .dut_d(dut_d),
      .dut_y(dut_y), .busy(busy), .done(done), .pass(pass),
      .err_count(err_count), .first_fail_vec(first_fail_vec),
      .first_fail_valid(first_fail_valid)
   );

   nand4_sweep_ctrl #(.SETTLE_CYCLES(1)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .start(start2), .abort(1'b0),
      .dut_a(a2), .dut_b(b2), .dut_c(c2), .dut_d(d2),
      .dut_y(y2), .busy(busy2), .done(done2), .pass(pass2),
      .err_count(err2), .first_fail_vec(ffv2),
      .first_fail_valid(ffvld2)
   );

   task automatic check(input string tag, input int obs, input int exp);
      n_chk++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d want %0d", tag, obs, exp);
      end
   endtask

   // Full sweep on the main instance. k=0 is the first SETTLE cycle,
   // observed at the falling edge. A stray start is pulsed at k=10.
   task automatic run_sweep(input string tag, input int mode, input int exp_err,
                            input int exp_ffv, input int exp_ffvld,
                            input int exp_pass);
      int busy_cyc, done_k, done_n, vec_bad;
      logic [3:0] v;
      y_mode = mode;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      busy_cyc = 0; done_k = -1; done_n = 0; vec_bad = 0;
      check({tag, "_err_clr"}, int'(err_count), 0);
      for (int k = 0; k < 60; k++) begin
         if (k == 10) start = 1'b1;
         if (k == 11) start = 1'b0;
         v = {dut_a, dut_b, dut_c, dut_d};
         if (busy) busy_cyc++;
         if (done) begin
            done_n++;
            if (done_k < 0) done_k = k;
         end
         if (k < 48 && v != 4'(k / 3)) vec_bad++;
         if (k >= 48 && v != 4'd0) vec_bad++;
         @(negedge clk);
      end
      check({tag, "_busy_cyc"}, busy_cyc, 48);
      check({tag, "_done_at"}, done_k, 48);
      check({tag, "_done_n"}, done_n, 1);
      check({tag, "_vec_seq"}, vec_bad, 0);
      check({tag, "_err"}, int'(err_count), exp_err);
      check({tag, "_ffvld"}, int'(first_fail_valid), exp_ffvld);
      if (exp_ffvld != 0) check({tag, "_ffv"}, int'(first_fail_vec), exp_ffv);
      check({tag, "_pass"}, int'(pass), exp_pass);
   endtask

   initial begin
      int done_k, done_n, busy_cyc;
      #12;
      // Reset state
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      check("rst_pass", int'(pass), 0);
      check("rst_err", int'(err_count), 0);
      check("rst_ffvld", int'(first_fail_valid), 0);
      check("rst_vec", int'({dut_a, dut_b, dut_c, dut_d}), 0);
      @(negedge clk); rst_n = 1'b1;

      // start together with abort in IDLE: abort wins
      @(negedge clk); start = 1'b1; abort = 1'b1;
      @(negedge clk); start = 1'b0; abort = 1'b0;
      check("sa_busy", int'(busy), 0);
      @(negedge clk);
      check("sa_busy2", int'(busy), 0);

      run_sweep("nand", M_NAND, 0, 0, 0, 1);
      run_sweep("aoi", M_AOI, 6, 3, 1, 0);
      run_sweep("stk1", M_STK1, 1, 15, 1, 0);
      run_sweep("stk0", M_STK0, 15, 0, 1, 0);

      // Abort during vector 5 SETTLE (k=15), stuck-at-0 cell
      y_mode = M_STK0;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      for (int k = 0; k < 15; k++) @(negedge clk);
      check("ab_vec5", int'({dut_a, dut_b, dut_c, dut_d}), 5);
      abort = 1'b1;
      @(negedge clk); abort = 1'b0;
      check("ab_busy", int'(busy), 0);
      check("ab_vec0", int'({dut_a, dut_b, dut_c, dut_d}), 0);
      check("ab_err", int'(err_count), 5);
      check("ab_ffv", int'(first_fail_vec), 0);
      check("ab_pass", int'(pass), 0);
      done_n = 0;
      for (int k = 0; k < 10; k++) begin
         if (done) done_n++;
         @(negedge clk);
      end
      check("ab_no_done", done_n, 0);
      run_sweep("post_ab", M_STK0, 15, 0, 1, 0);

      // Asynchronous reset between edges, mid-sweep
      y_mode = M_NAND;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      for (int k = 0; k < 20; k++) @(negedge clk);
      check("mid_busy", int'(busy), 1);
      #2 rst_n = 1'b0;
      #1;
      check("ar_busy", int'(busy), 0);
      check("ar_vec", int'({dut_a, dut_b, dut_c, dut_d}), 0);
      check("ar_err", int'(err_count), 0);
      check("ar_ffvld", int'(first_fail_valid), 0);
      @(negedge clk); rst_n = 1'b1;
      run_sweep("post_rst", M_NAND, 0, 0, 0, 1);

      // SETTLE_CYCLES=1 instance, restart at k=10 ignored
      @(negedge clk); start2 = 1'b1;
      @(negedge clk); start2 = 1'b0;
      done_k = -1; done_n = 0; busy_cyc = 0;
      for (int k = 0; k < 40; k++) begin
         if (k == 10) start2 = 1'b1;
         if (k == 11) start2 = 1'b0;
         if (busy2) busy_cyc++;
         if (done2) begin
            done_n++;
            if (done_k < 0) done_k = k;
         end
         @(negedge clk);
      end
      check("s1_done_at", done_k, 32);
      check("s1_done_n", done_n, 1);
      check("s1_busy_cyc", busy_cyc, 32);
      check("s1_err", int'(err2), 0);
      check("s1_pass", int'(pass2), 1);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
